// File: rtl/lcd1602_bus_receiver_if.sv
// LCD1602 parallel bus: rs/rw/enable/data as seen at the panel pins.
// The master drives the bus and the receiver only samples it.
interface lcd1602_bus_receiver_if;
    logic       rs;
    logic       rw;
    logic       enable;
    logic [7:0] data;

    modport master (output rs, rw, enable, data);
    modport slave  (input  rs, rw, enable, data);
endinterface

// File: rtl/lcd1602_bus_receiver.sv
// HD44780-style 16x2 responder: decodes bus bytes, keeps a DDRAM image.
// Bytes are taken on the synchronized falling edge of enable.
module lcd1602_bus_receiver #(
    parameter int         BUSY_CYCLES = 4,
    parameter logic [7:0] FILL_CHAR   = 8'h20
) (
    input  logic                   clk,
    input  logic                   reset,
    lcd1602_bus_receiver_if.slave  bus,
    input  logic [4:0]             rd_addr,
    output logic [7:0]             rd_char,
    output logic [6:0]             cursor_addr,
    output logic                   display_on,
    output logic                   func_seen,
    output logic                   busy,
    output logic                   char_strobe,
    output logic                   cmd_strobe,
    output logic [7:0]             last_byte,
    output logic                   error
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        BUSY
    } state_t;

    state_t      state;
    logic [1:0]  rs_s;
    logic [1:0]  rw_s;
    logic [1:0]  en_s;
    logic        en_d1;
    logic [7:0]  d_m;
    logic [7:0]  d_s;
    logic [4:0]  fill_idx;
    logic [15:0] cnt;
    logic [6:0]  ac;
    logic        id;
    logic [7:0]  mem [32];
    logic        we;
    logic [4:0]  waddr;
    logic [7:0]  wdata;
    logic        fall;

    // Next address counter value, wrapping between the two 16-cell lines.
    function automatic logic [6:0] ac_adv(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h0F)      r = 7'h40;
            else if (a == 7'h4F) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h4F;
            else if (a == 7'h40) r = 7'h0F;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic ac_ok(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    assign fall        = en_d1 & ~en_s[1];
    assign cursor_addr = ac;

    // Two-flop synchronizers for every bus pin plus enable history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_s  <= '0;
            rw_s  <= '0;
            en_s  <= '0;
            en_d1 <= 1'b0;
            d_m   <= '0;
            d_s   <= '0;
        end else begin
            rs_s  <= {rs_s[0], bus.rs};
            rw_s  <= {rw_s[0], bus.rw};
            en_s  <= {en_s[0], bus.enable};
            en_d1 <= en_s[1];
            d_m   <= bus.data;
            d_s   <= d_m;
        end
    end

    // DDRAM write port: clear fill has the port, else an accepted data byte.
    always_comb begin
        we    = 1'b0;
        waddr = fill_idx;
        wdata = FILL_CHAR;
        if (state == CLEAR) begin
            we = 1'b1;
        end else if (state == IDLE && fall && !rw_s[1] && rs_s[1]) begin
            we    = 1'b1;
            waddr = {ac[6], ac[3:0]};
            wdata = d_s;
        end
    end

    // DDRAM storage; contents are defined by the post-reset fill.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered readback, independent of the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_char <= '0;
        else       rd_char <= mem[rd_addr];
    end

    // Control FSM: fill, busy countdown and byte decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CLEAR;
            fill_idx    <= '0;
            cnt         <= '0;
            ac          <= '0;
            id          <= 1'b1;
            display_on  <= 1'b0;
            func_seen   <= 1'b0;
            busy        <= 1'b0;
            char_strobe <= 1'b0;
            cmd_strobe  <= 1'b0;
            last_byte   <= '0;
            error       <= 1'b0;
        end else begin
            char_strobe <= 1'b0;
            cmd_strobe  <= 1'b0;
            if (fall && (state != IDLE || rw_s[1])) error <= 1'b1;
            unique case (state)
                CLEAR: begin
                    busy     <= 1'b1;
                    fill_idx <= fill_idx + 5'd1;
                    if (fill_idx == 5'd31) begin
                        state <= BUSY;
                        cnt   <= BUSY_CYCLES[15:0];
                    end
                end
                BUSY: begin
                    cnt <= cnt - 16'd1;
                    if (cnt <= 16'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (fall && !rw_s[1]) begin
                        last_byte <= d_s;
                        busy      <= 1'b1;
                        state     <= BUSY;
                        cnt       <= BUSY_CYCLES[15:0];
                        if (rs_s[1]) begin
                            char_strobe <= 1'b1;
                            ac          <= ac_adv(ac, id);
                        end else begin
                            cmd_strobe <= 1'b1;
                            unique case (1'b1)
                                d_s == 8'h01: begin
                                    ac       <= '0;
                                    id       <= 1'b1;
                                    fill_idx <= '0;
                                    state    <= CLEAR;
                                end
                                d_s[7:1] == 7'h01: ac <= '0;
                                d_s[7:2] == 6'h01: id <= d_s[1];
                                d_s[7:3] == 5'h01: display_on <= d_s[2];
                                d_s[7:4] == 4'h1: ;
                                d_s[7:5] == 3'h1: func_seen <= 1'b1;
                                d_s[7:6] == 2'h1: ;
                                d_s[7]: begin
                                    if (ac_ok(d_s[6:0])) ac <= d_s[6:0];
                                    else                 error <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
